// File: rtl/lock_scheduler.sv
// Canal lock sequencer: arbitrates outer/inner passage requests and runs each transit
// end to end on the slow tick. Optional build macro ENTRY_TIMEOUT_EN adds an entry timeout.
module lock_scheduler #(
    parameter int LEVEL_W     = 8,
    parameter int STEP        = 1,
    parameter int GATE_TICKS  = 3,
    parameter int RESET_LEVEL = 0
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               req_out,
    input  logic               req_in,
    input  logic               arrived,
    input  logic               departed,
    input  logic [LEVEL_W-1:0] outer_level,
    input  logic [LEVEL_W-1:0] inner_level,
    output logic [LEVEL_W-1:0] lock_level,
    output logic               fill_valve,
    output logic               drain_valve,
    output logic               outer_gate_open,
    output logic               inner_gate_open,
    output logic               grant_out,
    output logic               grant_in,
    output logic               dir,
    output logic               busy,
    output logic               timeout,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_EQ_SRC     = 3'd1,
        S_WAIT_ENTER = 3'd2,
        S_SEAL_SRC   = 3'd3,
        S_EQ_DST     = 3'd4,
        S_WAIT_EXIT  = 3'd5,
        S_SEAL_DST   = 3'd6
    } state_t;

    localparam int                 CNT_W     = 16;
    localparam logic [LEVEL_W-1:0] STEP_L    = LEVEL_W'(STEP);
    localparam logic [LEVEL_W-1:0] RESET_L   = LEVEL_W'(RESET_LEVEL);
    localparam logic [CNT_W-1:0]   GATE_LAST = CNT_W'(GATE_TICKS - 1);
`ifdef ENTRY_TIMEOUT_EN
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
`endif

    state_t             r_state;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] r_target;
    logic               r_grant_out;
    logic               r_grant_in;
    logic               r_dir;
    logic               r_last_out;
    logic               r_arr_flag;
    logic               r_dep_flag;
    logic [CNT_W-1:0]   r_cnt;
`ifdef ENTRY_TIMEOUT_EN
    logic               r_timeout;
    logic               r_to_flag;
`endif

    logic               w_eq_state;
    logic               w_below;
    logic               w_above;
    logic [LEVEL_W-1:0] w_gap_up;
    logic [LEVEL_W-1:0] w_gap_dn;
    logic [LEVEL_W-1:0] w_next_level;
    logic               w_any_req;
    logic               w_pick_out;
    logic               w_granted_req;

    assign w_eq_state = (r_state == S_EQ_SRC) || (r_state == S_EQ_DST);
    assign w_below    = r_level < r_target;
    assign w_above    = r_level > r_target;
    assign w_gap_up   = r_target - r_level;
    assign w_gap_dn   = r_level - r_target;

    // One STEP toward the latched target, clamped so the level never overshoots.
    always_comb begin
        w_next_level = r_level;
        if (w_below) begin
            w_next_level = (w_gap_up <= STEP_L) ? r_target : r_level + STEP_L;
        end else if (w_above) begin
            w_next_level = (w_gap_dn <= STEP_L) ? r_target : r_level - STEP_L;
        end
    end

    // Requests are level-held: a side keeps its request high until served; dropping it
    // while the chamber equalises to the source side cancels the transit.
    assign w_any_req     = req_out || req_in;
    assign w_pick_out    = req_out && (!req_in || !r_last_out);
    assign w_granted_req = r_grant_out ? req_out : req_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_level     <= RESET_L;
            r_target    <= RESET_L;
            r_grant_out <= 1'b0;
            r_grant_in  <= 1'b0;
            r_dir       <= 1'b0;
            r_last_out  <= 1'b0;
            r_arr_flag  <= 1'b0;
            r_dep_flag  <= 1'b0;
            r_cnt       <= '0;
`ifdef ENTRY_TIMEOUT_EN
            r_timeout   <= 1'b0;
            r_to_flag   <= 1'b0;
`endif
        end else begin
`ifdef ENTRY_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (r_state == S_WAIT_ENTER && arrived) r_arr_flag <= 1'b1;
            if (r_state == S_WAIT_EXIT && departed) r_dep_flag <= 1'b1;
            if (tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_any_req) begin
                            r_grant_out <= w_pick_out;
                            r_grant_in  <= !w_pick_out;
                            r_dir       <= !w_pick_out;
                            r_target    <= w_pick_out ? outer_level : inner_level;
                            r_state     <= S_EQ_SRC;
                        end
                    end
                    S_EQ_SRC: begin
                        if (!w_granted_req) begin
                            r_grant_out <= 1'b0;
                            r_grant_in  <= 1'b0;
                            r_dir       <= 1'b0;
                            r_state     <= S_IDLE;
                        end else if (r_level == r_target) begin
                            r_cnt   <= '0;
                            r_state <= S_WAIT_ENTER;
                        end else begin
                            r_level <= w_next_level;
                        end
                    end
                    S_WAIT_ENTER: begin
                        if (r_arr_flag) begin
                            r_arr_flag <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= S_SEAL_SRC;
                        end
`ifdef ENTRY_TIMEOUT_EN
                        else if (r_cnt == TO_LAST) begin
                            r_arr_flag <= 1'b0;
                            r_timeout  <= 1'b1;
                            r_to_flag  <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_SEAL_SRC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
`endif
                    end
                    S_SEAL_SRC: begin
                        if (r_cnt == GATE_LAST) begin
                            r_cnt <= '0;
`ifdef ENTRY_TIMEOUT_EN
                            if (r_to_flag) begin
                                r_to_flag   <= 1'b0;
                                r_last_out  <= r_grant_out;
                                r_grant_out <= 1'b0;
                                r_grant_in  <= 1'b0;
                                r_dir       <= 1'b0;
                                r_state     <= S_IDLE;
                            end else
`endif
                            begin
                                r_target <= r_grant_out ? inner_level : outer_level;
                                r_state  <= S_EQ_DST;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_EQ_DST: begin
                        if (r_level == r_target) begin
                            r_state <= S_WAIT_EXIT;
                        end else begin
                            r_level <= w_next_level;
                        end
                    end
                    S_WAIT_EXIT: begin
                        if (r_dep_flag) begin
                            r_dep_flag <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= S_SEAL_DST;
                        end
                    end
                    S_SEAL_DST: begin
                        if (r_cnt == GATE_LAST) begin
                            r_cnt       <= '0;
                            r_last_out  <= r_grant_out;
                            r_grant_out <= 1'b0;
                            r_grant_in  <= 1'b0;
                            r_dir       <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // The source gate belongs to the granted side; the destination gate to the other.
    assign outer_gate_open = ((r_state == S_WAIT_ENTER) && r_grant_out) ||
                             ((r_state == S_WAIT_EXIT)  && r_grant_in);
    assign inner_gate_open = ((r_state == S_WAIT_ENTER) && r_grant_in) ||
                             ((r_state == S_WAIT_EXIT)  && r_grant_out);

    assign lock_level  = r_level;
    assign fill_valve  = w_eq_state && w_below;
    assign drain_valve = w_eq_state && w_above;
    assign grant_out   = r_grant_out;
    assign grant_in    = r_grant_in;
    assign dir         = r_dir;
    assign busy        = (r_state != S_IDLE);
    assign state_dbg   = r_state;
`ifdef ENTRY_TIMEOUT_EN
    assign timeout     = r_timeout;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_lock_scheduler.sv
// Directed bench for lock_scheduler: stimulus pushes hand-computed output snapshots
// into exp_q, a negedge monitor pops and compares them against the DUT.
module tb_lock_scheduler;

    localparam int W = 18;
    localparam logic [8:0] F_FILL  = 9'b100000000;
    localparam logic [8:0] F_DRAIN = 9'b010000000;
    localparam logic [8:0] F_OG    = 9'b001000000;
    localparam logic [8:0] F_IG    = 9'b000100000;
    localparam logic [8:0] F_GO    = 9'b000010000;
    localparam logic [8:0] F_GI    = 9'b000001000;
    localparam logic [8:0] F_DIR   = 9'b000000100;
    localparam logic [8:0] F_BUSY  = 9'b000000010;
    localparam logic [8:0] F_TO    = 9'b000000001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       req_out = 1'b0;
    logic       req_in = 1'b0;
    logic       arrived = 1'b0;
    logic       departed = 1'b0;
    logic [7:0] outer_level = 8'd0;
    logic [7:0] inner_level = 8'd0;
    logic       req4 = 1'b0;
    logic [7:0] outer4 = 8'd10;
    logic [7:0] inner4 = 8'd0;
    logic       zero = 1'b0;

    logic [7:0] lock_level, lock_level4;
    logic       fill_valve, drain_valve, outer_gate_open, inner_gate_open;
    logic       grant_out, grant_in, dir, busy, timeout;
    logic       fill4, drain4, og4, ig4, go4, gi4, dir4, busy4, to4;
    logic [2:0] state_dbg, state_dbg4;

    lock_scheduler u_dut (
        .clk(clk), .reset(reset), .tick(tick), .req_out(req_out), .req_in(req_in),
        .arrived(arrived), .departed(departed), .outer_level(outer_level),
        .inner_level(inner_level), .lock_level(lock_level), .fill_valve(fill_valve),
        .drain_valve(drain_valve), .outer_gate_open(outer_gate_open),
        .inner_gate_open(inner_gate_open), .grant_out(grant_out), .grant_in(grant_in),
        .dir(dir), .busy(busy), .timeout(timeout), .state_dbg(state_dbg)
    );

    lock_scheduler #(.STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .tick(tick), .req_out(req4), .req_in(zero),
        .arrived(zero), .departed(zero), .outer_level(outer4),
        .inner_level(inner4), .lock_level(lock_level4), .fill_valve(fill4),
        .drain_valve(drain4), .outer_gate_open(og4), .inner_gate_open(ig4),
        .grant_out(go4), .grant_in(gi4), .dir(dir4), .busy(busy4), .timeout(to4),
        .state_dbg(state_dbg4)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    logic [W-1:0] obs, obs4;
    assign obs  = {1'b0, lock_level, fill_valve, drain_valve, outer_gate_open,
                   inner_gate_open, grant_out, grant_in, dir, busy, timeout};
    assign obs4 = {1'b1, lock_level4, fill4, drain4, og4, ig4, go4, gi4, dir4, busy4, to4};

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        string        n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = e[W-1] ? obs4 : obs;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got level=%0d flags=%b, want level=%0d flags=%b (flags=fill,drain,og,ig,gout,gin,dir,busy,to)",
                         n, a[16:9], a[8:0], e[16:9], e[8:0]);
            end
        end
    end

    task automatic push_exp(input string n, input int lvl, input logic [8:0] f, input bit sel = 1'b0);
        exp_q.push_back({sel, 8'(lvl), f});
        name_q.push_back(n);
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pulse_arr();
        @(negedge clk);
        arrived = 1'b1;
        @(posedge clk);
        #1 arrived = 1'b0;
    endtask

    task automatic pulse_dep();
        @(negedge clk);
        departed = 1'b1;
        @(posedge clk);
        #1 departed = 1'b0;
    endtask

    // Asserted just after a rising edge and checked at the following falling edge.
    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        push_exp("reset", 0, 9'd0);
        push_exp("reset4", 0, 9'd0, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, want 0", exp_q.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        do_reset();

        // STEP=4 instance climbs 0 -> 4 -> 8 -> 10 without overshoot
        req4 = 1'b1;
        do_tick(); push_exp("s4_grant", 0, F_FILL | F_GO | F_BUSY, 1'b1);
        push_exp("idle_no_req", 0, 9'd0);
        do_tick(); push_exp("s4_lvl4", 4, F_FILL | F_GO | F_BUSY, 1'b1);
        do_tick(); push_exp("s4_lvl8", 8, F_FILL | F_GO | F_BUSY, 1'b1);
        do_tick(); push_exp("s4_clamp10", 10, F_GO | F_BUSY, 1'b1);
        do_tick(); push_exp("s4_enter", 10, F_OG | F_GO | F_BUSY, 1'b1);
        req4 = 1'b0;

        // Full outer -> inner transit
        outer_level = 8'd20;
        inner_level = 8'd10;
        req_out = 1'b1;
        do_tick(); push_exp("t1_grant", 0, F_FILL | F_GO | F_BUSY);
        for (int i = 1; i <= 20; i++) begin
            do_tick();
            push_exp("t1_fill", i, ((i < 20) ? F_FILL : 9'd0) | F_GO | F_BUSY);
        end
        outer_level = 8'd99;
        do_tick(); push_exp("t1_enter", 20, F_OG | F_GO | F_BUSY);
        do_tick(); push_exp("t1_wait", 20, F_OG | F_GO | F_BUSY);
        req_out = 1'b0;
        pulse_arr();
        do_tick(); push_exp("t1_seal1", 20, F_GO | F_BUSY);
        ticks(2);  push_exp("t1_seal3", 20, F_GO | F_BUSY);
        do_tick(); push_exp("t1_eq_dst", 20, F_DRAIN | F_GO | F_BUSY);
        inner_level = 8'd50;
        for (int i = 1; i <= 10; i++) begin
            do_tick();
            push_exp("t1_drain", 20 - i, ((i < 10) ? F_DRAIN : 9'd0) | F_GO | F_BUSY);
        end
        do_tick(); push_exp("t1_exit", 10, F_IG | F_GO | F_BUSY);
        pulse_dep();
        do_tick(); push_exp("t1_seal_dst", 10, F_GO | F_BUSY);
        ticks(2);  push_exp("t1_seal_dst3", 10, F_GO | F_BUSY);
        do_tick(); push_exp("t1_idle", 10, 9'd0);

        // Simultaneous requests: outer first after reset, then inner, then outer again
        do_reset();
        outer_level = 8'd3;
        inner_level = 8'd5;
        req_out = 1'b1;
        req_in = 1'b1;
        do_tick(); push_exp("t2_tie_out", 0, F_FILL | F_GO | F_BUSY);
        ticks(3);  push_exp("t2_src_lvl", 3, F_GO | F_BUSY);
        do_tick(); push_exp("t2_enter", 3, F_OG | F_GO | F_BUSY);
        pulse_arr();
        ticks(4);  push_exp("t2_eq_dst", 3, F_FILL | F_GO | F_BUSY);
        ticks(3);  push_exp("t2_exit", 5, F_IG | F_GO | F_BUSY);
        pulse_dep();
        ticks(4);  push_exp("t2_done", 5, 9'd0);
        do_tick(); push_exp("t2_tie_in", 5, F_GI | F_DIR | F_BUSY);
        do_tick(); push_exp("t2_in_enter", 5, F_IG | F_GI | F_DIR | F_BUSY);
        pulse_arr();
        ticks(4);  push_exp("t2_in_eq_dst", 5, F_DRAIN | F_GI | F_DIR | F_BUSY);
        ticks(3);  push_exp("t2_in_exit", 3, F_OG | F_GI | F_DIR | F_BUSY);
        pulse_dep();
        ticks(4);  push_exp("t2_in_done", 3, 9'd0);
        do_tick(); push_exp("t2_tie_out2", 3, F_GO | F_BUSY);

        // Abort during source equalise keeps the level and does not touch last_served
        do_reset();
        req_in = 1'b0;
        req_out = 1'b1;
        outer_level = 8'd20;
        do_tick(); push_exp("t3_grant", 0, F_FILL | F_GO | F_BUSY);
        ticks(7);  push_exp("t3_lvl7", 7, F_FILL | F_GO | F_BUSY);
        req_out = 1'b0;
        do_tick(); push_exp("t3_abort", 7, 9'd0);
        do_tick(); push_exp("t3_hold", 7, 9'd0);
        req_out = 1'b1;
        req_in = 1'b1;
        outer_level = 8'd10;
        do_tick(); push_exp("t3_tie_after_abort", 7, F_FILL | F_GO | F_BUSY);

        // arrived during equalise is not latched; gate then waits for a real arrival
        pulse_arr();
        ticks(4);  push_exp("t4_enter", 10, F_OG | F_GO | F_BUSY);
        ticks(3);  push_exp("t4_no_arrival", 10, F_OG | F_GO | F_BUSY);
        do_reset();
        req_out = 1'b0;
        req_in = 1'b0;
        do_tick(); push_exp("t4_idle_after_reset", 0, 9'd0);

`ifdef ENTRY_TIMEOUT_EN
        outer_level = 8'd0;
        inner_level = 8'd9;
        req_out = 1'b1;
        do_tick(); push_exp("to_grant", 0, F_GO | F_BUSY);
        do_tick(); push_exp("to_enter", 0, F_OG | F_GO | F_BUSY);
        ticks(15); push_exp("to_wait15", 0, F_OG | F_GO | F_BUSY);
        do_tick(); push_exp("to_pulse", 0, F_GO | F_BUSY | F_TO);
        @(posedge clk);
        #1 push_exp("to_one_clk", 0, F_GO | F_BUSY);
        ticks(2);  push_exp("to_seal", 0, F_GO | F_BUSY);
        req_out = 1'b0;
        do_tick(); push_exp("to_idle", 0, 9'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
